// File: rtl/trig_counter_snap_if.sv
// Trigger, acknowledge and status bundle of trig_counter_snap.
// The master drives the trigger pulses and the acknowledge; the slave returns the registered status.
interface trig_counter_snap_if #(
  parameter int WIDTH = 32
);
  logic [3:0]       ep_trigger;
  logic             snap_ack;
  logic [WIDTH-1:0] count;
  logic [15:0]      snap_lo;
  logic [15:0]      snap_hi;
  logic             snap_valid;
  logic [2:0]       flags;
  logic             led_act;

  modport master (
    output ep_trigger, snap_ack,
    input  count, snap_lo, snap_hi, snap_valid, flags, led_act
  );

  modport slave (
    input  ep_trigger, snap_ack,
    output count, snap_lo, snap_hi, snap_valid, flags, led_act
  );
endinterface

// File: rtl/trig_counter_snap.sv
// Trigger-driven up/down counter with an acknowledged snapshot and a stretched activity LED.
// Count and snapshot update one cycle after a trigger; there is no backpressure, and a snapshot that is not yet acknowledged is overwritten and flagged.
module trig_counter_snap #(
  parameter int          WIDTH    = 32,
  parameter int          SATURATE = 0,
  parameter logic [23:0] STRETCH  = 24'd5_000_000
) (
  input  logic                sys_clk,
  input  logic                reset,
  trig_counter_snap_if.slave  bus
);
  typedef enum logic {IDLE = 1'b0, HELD = 1'b1} state_t;

  localparam logic [WIDTH-1:0] ALL_ONES = '1;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] count_q, count_d;
  logic [WIDTH-1:0] snap_q, snap_d;
  logic [23:0]      stretch_q, stretch_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic             ovr_q, ovr_d;
  logic             valid_q, valid_d;
  logic             arm_q;
  logic [3:0]       trig;
  logic             clr, up, dn, snap;

  always_comb begin
    // Triggers are dropped until one full clock after reset release, so a pulse
    // that lands on the deasserting edge cannot race the reset.
    trig      = arm_q ? bus.ep_trigger : 4'b0000;
    clr       = trig[0];
    up        = trig[1];
    dn        = trig[2];
    snap      = trig[3];
    count_d   = count_q;
    snap_d    = snap_q;
    state_d   = state_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    ovr_d     = ovr_q;
    stretch_d = (stretch_q != 24'd0) ? stretch_q - 24'd1 : 24'd0;

    if (clr || up || dn)
      stretch_d = STRETCH;

    if (clr) begin
      count_d = '0;
      ovf_d   = 1'b0;
      unf_d   = 1'b0;
      ovr_d   = 1'b0;
    end else if (up) begin
      if (count_q == ALL_ONES) begin
        ovf_d   = 1'b1;
        count_d = (SATURATE != 0) ? ALL_ONES : '0;
      end else begin
        count_d = count_q + 1'b1;
      end
    end else if (dn) begin
      if (count_q == '0) begin
        unf_d   = 1'b1;
        count_d = (SATURATE != 0) ? '0 : ALL_ONES;
      end else begin
        count_d = count_q - 1'b1;
      end
    end

    // Snapshot always takes the pre-edge count, and both halves come from one register.
    case (state_q)
      IDLE: begin
        if (snap) begin
          snap_d  = count_q;
          state_d = HELD;
        end
      end
      HELD: begin
        if (snap) begin
          snap_d = count_q;
          if (!bus.snap_ack && !clr)
            ovr_d = 1'b1;
        end else if (bus.snap_ack) begin
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    valid_d = (state_d == HELD);
  end

  always_ff @(posedge sys_clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      count_q   <= '0;
      snap_q    <= '0;
      stretch_q <= 24'd0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      ovr_q     <= 1'b0;
      valid_q   <= 1'b0;
      arm_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      snap_q    <= snap_d;
      stretch_q <= stretch_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      ovr_q     <= ovr_d;
      valid_q   <= valid_d;
      arm_q     <= 1'b1;
    end
  end

  assign bus.count      = count_q;
  assign bus.snap_lo    = snap_q[15:0];
  assign bus.snap_hi    = 16'(snap_q[WIDTH-1:16]);
  assign bus.snap_valid = valid_q;
  assign bus.flags      = {ovr_q, unf_q, ovf_q};
  assign bus.led_act    = (stretch_q != 24'd0);
endmodule

// File: tb/tb_trig_counter_snap.sv
// Directed bench for trig_counter_snap: a wrap instance and a clamp instance, both with a 4-cycle LED stretch.
module tb_trig_counter_snap;
  logic sys_clk = 1'b0;
  logic reset   = 1'b1;
  int   total   = 0;
  int   bad     = 0;
  logic [31:0] pre_val;

  trig_counter_snap_if #(.WIDTH(32)) if0 ();
  trig_counter_snap_if #(.WIDTH(32)) if1 ();

  trig_counter_snap #(.WIDTH(32), .SATURATE(0), .STRETCH(24'd4)) dut0 (
    .sys_clk(sys_clk), .reset(reset), .bus(if0));
  trig_counter_snap #(.WIDTH(32), .SATURATE(1), .STRETCH(24'd4)) dut1 (
    .sys_clk(sys_clk), .reset(reset), .bus(if1));

  always #5 sys_clk = ~sys_clk;

  typedef struct {
    logic [3:0]  trig;
    logic        ack;
    logic [31:0] cnt;
    logic [2:0]  flg;
    logic        vld;
    logic [15:0] lo;
    logic [15:0] hi;
  } vec_t;

  vec_t tbl[15];

  // trigger bits: [3]=snap_req [2]=countdown [1]=countup [0]=clear
  localparam logic [3:0] T_CLR = 4'b0001;
  localparam logic [3:0] T_UP  = 4'b0010;
  localparam logic [3:0] T_DN  = 4'b0100;
  localparam logic [3:0] T_SN  = 4'b1000;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Called at a falling edge: drive for one rising edge, return at the next falling edge.
  task automatic cyc0(input logic [3:0] t, input logic a);
    if0.ep_trigger = t;
    if0.snap_ack   = a;
    @(negedge sys_clk);
    if0.ep_trigger = 4'b0000;
    if0.snap_ack   = 1'b0;
  endtask

  task automatic cyc1(input logic [3:0] t, input logic a);
    if1.ep_trigger = t;
    if1.snap_ack   = a;
    @(negedge sys_clk);
    if1.ep_trigger = 4'b0000;
    if1.snap_ack   = 1'b0;
  endtask

  task automatic preload0(input logic [31:0] v);
    pre_val = v;
    force dut0.count_q = pre_val;
    #1;
    release dut0.count_q;
  endtask

  task automatic preload1(input logic [31:0] v);
    pre_val = v;
    force dut1.count_q = pre_val;
    #1;
    release dut1.count_q;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tbl[0]  = '{T_UP,        1'b0, 32'd1,         3'b000, 1'b0, 16'd0, 16'd0};
    tbl[1]  = '{T_UP,        1'b0, 32'd2,         3'b000, 1'b0, 16'd0, 16'd0};
    tbl[2]  = '{T_UP,        1'b0, 32'd3,         3'b000, 1'b0, 16'd0, 16'd0};
    tbl[3]  = '{T_DN,        1'b0, 32'd2,         3'b000, 1'b0, 16'd0, 16'd0};
    tbl[4]  = '{T_UP | T_DN, 1'b0, 32'd3,         3'b000, 1'b0, 16'd0, 16'd0};
    tbl[5]  = '{T_SN | T_UP, 1'b0, 32'd4,         3'b000, 1'b1, 16'd3, 16'd0};
    tbl[6]  = '{T_SN,        1'b0, 32'd4,         3'b100, 1'b1, 16'd4, 16'd0};
    tbl[7]  = '{4'b0000,     1'b1, 32'd4,         3'b100, 1'b0, 16'd4, 16'd0};
    tbl[8]  = '{T_SN | T_UP, 1'b0, 32'd5,         3'b100, 1'b1, 16'd4, 16'd0};
    tbl[9]  = '{T_SN | T_UP, 1'b1, 32'd6,         3'b100, 1'b1, 16'd5, 16'd0};
    tbl[10] = '{T_CLR | T_DN, 1'b0, 32'd0,        3'b000, 1'b1, 16'd5, 16'd0};
    tbl[11] = '{T_DN,        1'b0, 32'hFFFF_FFFF, 3'b010, 1'b1, 16'd5, 16'd0};
    tbl[12] = '{T_UP,        1'b0, 32'd0,         3'b011, 1'b1, 16'd5, 16'd0};
    tbl[13] = '{T_CLR | T_UP, 1'b0, 32'd0,        3'b000, 1'b1, 16'd5, 16'd0};
    tbl[14] = '{4'b0000,     1'b1, 32'd0,         3'b000, 1'b0, 16'd5, 16'd0};

    if0.ep_trigger = 4'b0000; if0.snap_ack = 1'b0;
    if1.ep_trigger = 4'b0000; if1.snap_ack = 1'b0;

    #1;
    chk("rst_count",  if0.count, 32'd0);
    chk("rst_flags",  32'(if0.flags), 32'd0);
    chk("rst_valid",  32'(if0.snap_valid), 32'd0);
    chk("rst_led",    32'(if0.led_act), 32'd0);
    chk("rst_count1", if1.count, 32'd0);

    @(negedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);

    for (int i = 0; i < 15; i++) begin
      cyc0(tbl[i].trig, tbl[i].ack);
      chk($sformatf("v%0d_count", i), if0.count, tbl[i].cnt);
      chk($sformatf("v%0d_flags", i), 32'(if0.flags), 32'(tbl[i].flg));
      chk($sformatf("v%0d_valid", i), 32'(if0.snap_valid), 32'(tbl[i].vld));
      chk($sformatf("v%0d_lo", i), 32'(if0.snap_lo), 32'(tbl[i].lo));
      chk($sformatf("v%0d_hi", i), 32'(if0.snap_hi), 32'(tbl[i].hi));
    end

    // LED stretch: single pulse, then a second pulse two cycles after the first.
    for (int i = 0; i < 6; i++) cyc0(4'b0000, 1'b0);
    chk("led_quiet", 32'(if0.led_act), 32'd0);
    cyc0(T_UP, 1'b0);
    chk("led_p1_0", 32'(if0.led_act), 32'd1);
    for (int i = 1; i < 4; i++) begin
      cyc0(4'b0000, 1'b0);
      chk($sformatf("led_p1_%0d", i), 32'(if0.led_act), 32'd1);
    end
    cyc0(4'b0000, 1'b0);
    chk("led_p1_off", 32'(if0.led_act), 32'd0);
    cyc0(T_UP, 1'b0);
    cyc0(4'b0000, 1'b0);
    cyc0(T_UP, 1'b0);
    for (int i = 0; i < 3; i++) begin
      chk($sformatf("led_p2_%0d", i), 32'(if0.led_act), 32'd1);
      cyc0(4'b0000, 1'b0);
    end
    chk("led_p2_3", 32'(if0.led_act), 32'd1);
    cyc0(4'b0000, 1'b0);
    chk("led_p2_off", 32'(if0.led_act), 32'd0);

    // Limits: wrap instance and clamp instance from all-ones.
    cyc0(T_CLR, 1'b0);
    preload0(32'hFFFF_FFFF);
    cyc0(T_UP, 1'b0);
    chk("wrap_count", if0.count, 32'd0);
    chk("wrap_flags", 32'(if0.flags), 32'b001);
    cyc1(T_CLR, 1'b0);
    preload1(32'hFFFF_FFFF);
    cyc1(T_UP, 1'b0);
    chk("sat_count", if1.count, 32'hFFFF_FFFF);
    chk("sat_flags", 32'(if1.flags), 32'b001);
    cyc1(T_CLR, 1'b0);
    cyc1(T_DN, 1'b0);
    chk("sat_dn_count", if1.count, 32'd0);
    chk("sat_dn_flags", 32'(if1.flags), 32'b010);

    // Snapshot across the 16-bit boundary, then overrun and acknowledge.
    cyc0(T_CLR, 1'b0);
    preload0(32'h0001_2345);
    cyc0(T_SN | T_UP, 1'b0);
    chk("snap_hi",    32'(if0.snap_hi), 32'h0001);
    chk("snap_lo",    32'(if0.snap_lo), 32'h2345);
    chk("snap_valid", 32'(if0.snap_valid), 32'd1);
    chk("snap_count", if0.count, 32'h0001_2346);
    cyc0(T_SN, 1'b0);
    chk("ovr_lo",    32'(if0.snap_lo), 32'h2346);
    chk("ovr_flags", 32'(if0.flags), 32'b100);
    cyc0(4'b0000, 1'b1);
    chk("ack_valid", 32'(if0.snap_valid), 32'd0);
    chk("ack_lo",    32'(if0.snap_lo), 32'h2346);

    // Async reset while HELD with count 7, then a pulse on the release edge.
    cyc0(T_CLR, 1'b0);
    for (int i = 0; i < 7; i++) cyc0(T_UP, 1'b0);
    cyc0(T_SN, 1'b0);
    chk("pre_rst_count", if0.count, 32'd7);
    chk("pre_rst_valid", 32'(if0.snap_valid), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("arst_count", if0.count, 32'd0);
    chk("arst_lo",    32'(if0.snap_lo), 32'd0);
    chk("arst_hi",    32'(if0.snap_hi), 32'd0);
    chk("arst_valid", 32'(if0.snap_valid), 32'd0);
    chk("arst_flags", 32'(if0.flags), 32'd0);
    chk("arst_led",   32'(if0.led_act), 32'd0);
    #1 if0.ep_trigger = T_UP;
    @(posedge sys_clk);
    reset = 1'b0;
    @(negedge sys_clk);
    if0.ep_trigger = 4'b0000;
    chk("rel_count", if0.count, 32'd0);
    chk("rel_valid", 32'(if0.snap_valid), 32'd0);
    cyc0(4'b0000, 1'b0);
    cyc0(T_UP, 1'b0);
    chk("post_rst_count", if0.count, 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
